// File: rtl/wishbone_master_arbiter_pkg.sv
// Shared types and constants for the wishbone master request arbiter.
package wishbone_master_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

  // Round-robin successor of idx among n channels.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wishbone_master_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_priority_picker #(
  parameter int unsigned N = 3,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] cidx;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    cidx    = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = (32'(ptr_i) + off) % N;
      cidx = IDX_W'(cand);
      if (!valid_o && req_i[cidx]) begin
        valid_o     = 1'b1;
        idx_o       = cidx;
        gnt_o[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wishbone_master_arbiter.sv
// Round-robin arbiter sharing the wishbone master's single-transfer port between clients,
// with a watchdog that aborts transfers the bus never completes.
module wishbone_master_arbiter
  import wishbone_master_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o,
  output logic                      burst_active,
  output logic [ADDR_W-1:0]         write_addr,
  output logic [DATA_W-1:0]         write_data,
  output logic                      write_en,
  input  logic                      write_ready,
  output logic [ADDR_W-1:0]         read_addr,
  output logic                      read_en,
  input  logic [DATA_W-1:0]         read_data,
  input  logic                      read_ready
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic                we_q, we_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   write_addr_q, write_addr_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [ADDR_W-1:0]   read_addr_q, read_addr_d;
  logic                write_en_q, write_en_d;
  logic                read_en_q, read_en_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;

  logic [NUM_REQ-1:0]  pick_gnt_c;
  logic [IDX_W-1:0]    pick_idx_c;
  logic                pick_valid_c;
  logic                done_c;
  logic                timeout_c;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr_i[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata_i[g*DATA_W +: DATA_W];
  end

  rr_priority_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt_c),
    .idx_o   (pick_idx_c),
    .valid_o (pick_valid_c)
  );

  // Only the ready matching the transfer direction completes it; completion beats timeout.
  assign done_c    = (state_q == ARB_WAIT) && (we_q ? write_ready : read_ready);
  assign timeout_c = (state_q == ARB_WAIT) && !done_c &&
                     (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    we_d         = we_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    read_addr_d  = read_addr_q;
    rdata_d      = rdata_q;
    wdog_d       = wdog_q;
    write_en_d   = 1'b0;
    read_en_d    = 1'b0;
    ack_d        = '0;
    err_d        = '0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid_c) begin
          owner_d = pick_idx_c;
          we_d    = req_we_i[pick_idx_c];
          grant_d = pick_gnt_c;
          busy_d  = 1'b1;
          state_d = ARB_ISSUE;
          if (req_we_i[pick_idx_c]) begin
            write_addr_d = addr_arr[pick_idx_c];
            write_data_d = wdata_arr[pick_idx_c];
            write_en_d   = 1'b1;
          end else begin
            read_addr_d = addr_arr[pick_idx_c];
            read_en_d   = 1'b1;
          end
        end
      end

      ARB_ISSUE: begin
        wdog_d  = '0;
        state_d = ARB_WAIT;
      end

      ARB_WAIT: begin
        if (done_c || timeout_c) begin
          ack_d[owner_q] = done_c;
          err_d[owner_q] = timeout_c;
          if (done_c && !we_q) begin
            rdata_d = read_data;
          end
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = IDX_W'(rr_next(32'(owner_q), NUM_REQ));
          state_d = ARB_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      we_q         <= 1'b0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      read_addr_q  <= '0;
      write_en_q   <= 1'b0;
      read_en_q    <= 1'b0;
      ack_q        <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      read_addr_q  <= read_addr_d;
      write_en_q   <= write_en_d;
      read_en_q    <= read_en_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      wdog_q       <= wdog_d;
    end
  end

  assign ack_o        = ack_q;
  assign err_o        = err_q;
  assign rdata_o      = rdata_q;
  assign grant_o      = grant_q;
  assign busy_o       = busy_q;
  assign burst_active = busy_q;
  assign write_addr   = write_addr_q;
  assign write_data   = write_data_q;
  assign write_en     = write_en_q;
  assign read_addr    = read_addr_q;
  assign read_en      = read_en_q;

endmodule

// File: tb/tb_wishbone_master_arbiter.sv
// Randomized bench for wishbone_master_arbiter against a transaction-level timing model.
module tb_wishbone_master_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned T  = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    ack, err, grant;
  logic [DW-1:0]   rdata;
  logic            busy, burst_active;
  logic [AW-1:0]   write_addr, read_addr;
  logic [DW-1:0]   write_data, read_data;
  logic            write_en, write_ready, read_en, read_ready;

  always #5 clk = ~clk;

  wishbone_master_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .req_i(req), .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .ack_o(ack), .err_o(err), .rdata_o(rdata), .grant_o(grant),
    .busy_o(busy), .burst_active(burst_active),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
    .write_ready(write_ready),
    .read_addr(read_addr), .read_en(read_en), .read_data(read_data),
    .read_ready(read_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, when its strobe fired, rotation pointer, held outputs.
  int            owner = -1;
  int            strobe_edge = 0;
  int            ptr = 0;
  int            edge_n = 0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_waddr = '0, m_raddr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  logic [N-1:0]  exp_ack, exp_err;
  bit            exp_wen, exp_ren;
  bit            pend [N];
  bit            rand_en = 1'b0;
  int            rdy_edge = -1;
  bit            rdy_we = 1'b0;
  int            n_acks = 0, n_errs = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_grant"}, 32'(grant), 0);
    check({pfx, "_ack"}, 32'(ack), 0);
    check({pfx, "_err"}, 32'(err), 0);
    check({pfx, "_busy"}, 32'(busy), 0);
    check({pfx, "_burst"}, 32'(burst_active), 0);
    check({pfx, "_wen"}, 32'(write_en), 0);
    check({pfx, "_ren"}, 32'(read_en), 0);
    check({pfx, "_rdata"}, 32'(rdata), 0);
    check({pfx, "_waddr"}, 32'(write_addr), 0);
    check({pfx, "_wdata"}, 32'(write_data), 0);
    check({pfx, "_raddr"}, 32'(read_addr), 0);
  endtask

  task automatic model_reset();
    owner = -1; ptr = 0; m_we = 1'b0;
    m_waddr = '0; m_raddr = '0; m_wdata = '0; m_rdata = '0;
    rdy_edge = -1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    write_ready = 1'b0; read_ready = 1'b0; read_data = '0;
  endtask

  task automatic raise_req(input int c, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[c] = 1'b1;
    req[c] = 1'b1;
    req_we[c] = we;
    req_addr[c*AW +: AW] = a;
    req_wdata[c*DW +: DW] = d;
  endtask

  // One clock: predict outputs from the inputs present at the edge, compare, then drive.
  task automatic step();
    logic [N-1:0]    d_req, d_we;
    logic [N*AW-1:0] d_addr;
    logic [N*DW-1:0] d_wdata;
    logic            d_wr, d_rr;
    logic [DW-1:0]   d_rd;
    logic [N-1:0]    exp_grant;
    int              dly, r;
    d_req = req; d_we = req_we; d_addr = req_addr; d_wdata = req_wdata;
    d_wr = write_ready; d_rr = read_ready; d_rd = read_data;
    @(posedge clk);
    edge_n++;
    #1;
    exp_ack = '0; exp_err = '0; exp_wen = 1'b0; exp_ren = 1'b0;
    if (owner < 0) begin
      for (int off = 0; off < N; off++) begin
        int c;
        c = (ptr + off) % N;
        if (owner < 0 && d_req[c]) begin
          owner = c;
          m_we = d_we[c];
          strobe_edge = edge_n;
          if (m_we) begin
            m_waddr = d_addr[c*AW +: AW];
            m_wdata = d_wdata[c*DW +: DW];
            exp_wen = 1'b1;
          end else begin
            m_raddr = d_addr[c*AW +: AW];
            exp_ren = 1'b1;
          end
        end
      end
    end else if (edge_n >= strobe_edge + 2) begin
      if ((m_we && d_wr) || (!m_we && d_rr)) begin
        exp_ack[owner] = 1'b1;
        if (!m_we) m_rdata = d_rd;
        ptr = (owner + 1) % N;
        owner = -1;
        n_acks++;
      end else if (edge_n == strobe_edge + 1 + int'(T)) begin
        exp_err[owner] = 1'b1;
        ptr = (owner + 1) % N;
        owner = -1;
        n_errs++;
      end
    end
    exp_grant = (owner < 0) ? '0 : N'(1 << owner);

    check("grant", 32'(grant), 32'(exp_grant));
    check("busy", 32'(busy), 32'(owner >= 0));
    check("burst_active", 32'(burst_active), 32'(owner >= 0));
    check("write_en", 32'(write_en), 32'(exp_wen));
    check("read_en", 32'(read_en), 32'(exp_ren));
    check("ack", 32'(ack), 32'(exp_ack));
    check("err", 32'(err), 32'(exp_err));
    check("rdata", 32'(rdata), 32'(m_rdata));
    check("write_addr", 32'(write_addr), 32'(m_waddr));
    check("write_data", 32'(write_data), 32'(m_wdata));
    check("read_addr", 32'(read_addr), 32'(m_raddr));

    for (int i = 0; i < N; i++) begin
      if (exp_ack[i] || exp_err[i]) begin
        pend[i] = 1'b0;
        req[i] = 1'b0;
      end
      if (rand_en && !pend[i] && $urandom_range(0, 2) == 0)
        raise_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
    end

    // Bus responder: mostly prompt, sometimes in ISSUE, at the timeout boundary, late or never.
    if (exp_wen || exp_ren) begin
      r = int'($urandom_range(0, 15));
      if (r < 10) dly = r + 1;
      else if (r == 10) dly = 0;
      else if (r == 11) dly = int'(T);
      else if (r == 12) dly = int'(T) + 1;
      else dly = -1;
      rdy_edge = (dly < 0) ? -1 : edge_n + 1 + dly;
      rdy_we = exp_wen;
    end
    write_ready = (rdy_edge == edge_n + 1) && rdy_we;
    read_ready  = (rdy_edge == edge_n + 1) && !rdy_we;
    if ($urandom_range(0, 7) == 0) begin
      if (owner >= 0) begin
        if (m_we) read_ready = 1'b1;
        else write_ready = 1'b1;
      end else if ($urandom_range(0, 1) == 1) write_ready = 1'b1;
      else read_ready = 1'b1;
    end
    read_data = DW'($urandom);
  endtask

  initial begin
    bit reached;
    rst = 1'b1;
    model_reset();
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    edge_n = 0;

    raise_req(1, 1'b1, 8'h80, 8'hAA);
    repeat (80) step();
    raise_req(0, 1'b0, 8'h10, 8'h00);
    repeat (80) step();
    for (int i = 0; i < N; i++) raise_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
    repeat (80) step();

    rand_en = 1'b1;
    repeat (3000) step();

    reached = 1'b0;
    for (int k = 0; k < 400 && !reached; k++) begin
      step();
      reached = (owner >= 0) && (edge_n >= strobe_edge + 3) && (edge_n < strobe_edge + int'(T));
    end
    check("rst_mid_wait_reached", 32'(reached), 1);
    #2 rst = 1'b1;
    #1;
    check_zero("rst_mid");
    model_reset();
    rand_en = 1'b0;
    @(posedge clk);
    edge_n++;
    #1;
    check_zero("rst_held");
    rst = 1'b0;
    raise_req(1, 1'b1, 8'h3C, 8'hC3);
    repeat (80) step();

    rand_en = 1'b1;
    repeat (300) step();
    rand_en = 1'b0;
    repeat (150) step();

    check("some_acks", 32'(n_acks > 20), 1);
    check("some_errs", 32'(n_errs > 0), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
